// File: rtl/ledr_pwm_blink_driver_if.sv
// rtl/ledr_pwm_blink_driver_if.sv - Avalon-MM register port for the LEDR PWM/blink driver
interface ledr_pwm_blink_driver_if;
    logic [1:0]  avs_address;
    logic        avs_chipselect;
    logic        avs_write_n;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address, avs_chipselect, avs_write_n, avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_chipselect, avs_write_n, avs_writedata,
        output avs_readdata
    );
endinterface

// File: rtl/ledr_pwm_blink_driver.sv
// rtl/ledr_pwm_blink_driver.sv - LEDR pin driver with global PWM brightness and per-bit blink
module ledr_pwm_blink_driver #(
    parameter int WIDTH         = 18,
    parameter int PRESCALE      = 500,
    parameter int BLINK_PERIODS = 1024
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [WIDTH-1:0]       in_pattern,
    ledr_pwm_blink_driver_if.slave avs,
    output logic [WIDTH-1:0]       led_out,
    output logic                   period_start
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_PERIODS - 1);
    localparam logic [3:0]    PWM_MAX   = 4'd14;

    logic             ctrl_enable;
    logic             ctrl_blink_en;
    logic [3:0]       ctrl_duty;
    logic [WIDTH-1:0] blink_mask;

    logic [PW-1:0]    presc;
    logic [3:0]       pwm_cnt;
    logic [BW-1:0]    blink_cnt;
    logic             blink_phase;

    logic [WIDTH-1:0] sh_pattern;
    logic [3:0]       sh_duty;
    logic [WIDTH-1:0] sh_mask;
    logic             sh_blink_en;

    logic             wr;
    logic             tick;
    logic             boundary;
    logic             pwm_on;
    logic             unused_wdata;

    assign wr           = avs.avs_chipselect && !avs.avs_write_n;
    assign tick         = ctrl_enable && (presc == PRESC_MAX);
    assign boundary     = tick && (pwm_cnt == PWM_MAX);
    assign pwm_on       = (pwm_cnt < sh_duty);
    assign unused_wdata = ^avs.avs_writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_enable   <= 1'b1;
            ctrl_blink_en <= 1'b0;
            ctrl_duty     <= 4'hF;
            blink_mask    <= '0;
        end else if (wr) begin
            case (avs.avs_address)
                2'd0: begin
                    ctrl_enable   <= avs.avs_writedata[0];
                    ctrl_blink_en <= avs.avs_writedata[1];
                    ctrl_duty     <= avs.avs_writedata[11:8];
                end
                2'd1:    blink_mask <= avs.avs_writedata[WIDTH-1:0];
                default: ;
            endcase
        end
    end

    // All timebase state is held at zero while disabled so re-enable restarts a clean period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc       <= '0;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!ctrl_enable) begin
            presc       <= '0;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick)
                pwm_cnt <= (pwm_cnt == PWM_MAX) ? 4'd0 : pwm_cnt + 4'd1;
            if (boundary) begin
                if (blink_cnt == BLINK_MAX) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    // Shadows see the register values from before any write landing on the boundary edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_pattern  <= '0;
            sh_duty     <= 4'hF;
            sh_mask     <= '0;
            sh_blink_en <= 1'b0;
        end else if (!ctrl_enable || boundary) begin
            sh_pattern  <= in_pattern;
            sh_duty     <= ctrl_duty;
            sh_mask     <= blink_mask;
            sh_blink_en <= ctrl_blink_en;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_out      <= '0;
            period_start <= 1'b0;
        end else begin
            period_start <= boundary;
            if (ctrl_enable)
                led_out <= sh_pattern & {WIDTH{pwm_on}}
                           & ~(sh_mask & {WIDTH{blink_phase & sh_blink_en}});
            else
                led_out <= '0;
        end
    end

    always_comb begin
        avs.avs_readdata = '0;
        case (avs.avs_address)
            2'd0: begin
                avs.avs_readdata[0]    = ctrl_enable;
                avs.avs_readdata[1]    = ctrl_blink_en;
                avs.avs_readdata[11:8] = ctrl_duty;
            end
            2'd1: avs.avs_readdata[WIDTH-1:0] = blink_mask;
            2'd2: begin
                avs.avs_readdata[0]    = blink_phase;
                avs.avs_readdata[11:8] = sh_duty;
                avs.avs_readdata[16]   = ctrl_enable;
            end
            default: ;
        endcase
    end
endmodule
